// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// FSM state encoding, owner IDs and the default error read-data pattern.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Width of a counter that must reach limit-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch (m0), load/store (m1) and memory-subsystem (s) signals
// around the arbiter; the arbiter takes the slave view, the environment the master view.
interface mem_port_arbiter_if;

  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_rdata;
  logic        m0_ready;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ready;
  logic        m1_err;

  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_we;
  logic        s_re;
  logic [31:0] s_rdata;
  logic        s_ready;

  modport slave (
    input  m0_req, m0_addr,
    output m0_rdata, m0_ready, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ready, m1_err,
    output s_addr, s_wdata, s_we, s_re,
    input  s_rdata, s_ready
  );

  modport master (
    output m0_req, m0_addr,
    input  m0_rdata, m0_ready, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ready, m1_err,
    input  s_addr, s_wdata, s_we, s_re,
    output s_rdata, s_ready
  );

endinterface

// File: rtl/mem_port_watchdog.sv
// Transaction watchdog: counts enabled cycles from zero and flags expiry on the
// TIMEOUT_CYCLES-th one; clear wins over enable and returns the count to zero.
module mem_port_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt_q;
  logic [CW-1:0] tmo_cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (clear) begin
      tmo_cnt_d = '0;
    end else if (enable) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  assign expire = enable && !clear && (tmo_cnt_q == LAST);

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (m0) and load/store (m1): m1 priority with
// bounded m0 starvation, registered strobes, one-cycle response, watchdog abort.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                clk,
  input  logic                resetn,
  mem_port_arbiter_if.slave   bus,
  output logic                timeout_pulse
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_e  state_q,    state_d;
  logic        owner_q,    owner_d;
  logic [3:0]  starve_q,   starve_d;
  logic [31:0] s_addr_q,   s_addr_d;
  logic [31:0] s_wdata_q,  s_wdata_d;
  logic        s_we_q,     s_we_d;
  logic        s_re_q,     s_re_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m0_err_q,   m0_err_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        m1_ready_q, m1_ready_d;
  logic        m1_err_q,   m1_err_d;
  logic        tmo_q,      tmo_d;

  logic        any_req;
  logic        grant_m0;
  logic        wd_clear;
  logic        wd_enable;
  logic        wd_expire;
  logic        done;
  logic [31:0] rsp_data;
  logic        rsp_err;

  mem_port_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (resetn),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // m1 wins unless m0 is alone or has waited through STARVE_LIMIT m1 grants.
  assign any_req  = bus.m0_req || bus.m1_req;
  assign grant_m0 = bus.m0_req && (!bus.m1_req || (starve_q == STARVE_MAX));

  // s_ready outranks the watchdog when both land on the same BUSY cycle.
  assign done     = bus.s_ready || wd_expire;
  assign rsp_data = bus.s_ready ? bus.s_rdata : ERR_DATA;
  assign rsp_err  = !bus.s_ready;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    starve_d   = starve_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_we_d     = s_we_q;
    s_re_d     = s_re_q;
    m0_rdata_d = '0;
    m0_ready_d = 1'b0;
    m0_err_d   = 1'b0;
    m1_rdata_d = '0;
    m1_ready_d = 1'b1 & 1'b0;
    m1_err_d   = 1'b0;
    tmo_d      = 1'b0;
    wd_clear   = 1'b1;
    wd_enable  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_m0 || !bus.m0_req) begin
          starve_d = '0;
        end else if (starve_q < STARVE_MAX) begin
          starve_d = starve_q + 4'd1;
        end

        if (any_req) begin
          state_d   = ST_BUSY;
          owner_d   = grant_m0 ? OWN_M0 : OWN_M1;
          s_addr_d  = grant_m0 ? bus.m0_addr : bus.m1_addr;
          s_wdata_d = grant_m0 ? 32'h0 : bus.m1_wdata;
          s_we_d    = !grant_m0 && bus.m1_we;
          s_re_d    = grant_m0 || !bus.m1_we;
        end
      end

      ST_BUSY: begin
        wd_clear  = 1'b0;
        wd_enable = 1'b1;
        if (done) begin
          state_d = ST_RESP;
          s_we_d  = 1'b0;
          s_re_d  = 1'b0;
          tmo_d   = rsp_err;
          if (owner_q == OWN_M0) begin
            m0_ready_d = 1'b1;
            m0_rdata_d = rsp_data;
            m0_err_d   = rsp_err;
          end else begin
            m1_ready_d = 1'b1;
            m1_rdata_d = rsp_data;
            m1_err_d   = rsp_err;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A reset mid-transaction simply discards it; nothing is replayed afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_M0;
      starve_q   <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_we_q     <= 1'b0;
      s_re_q     <= 1'b0;
      m0_rdata_q <= '0;
      m0_ready_q <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_rdata_q <= '0;
      m1_ready_q <= 1'b0;
      m1_err_q   <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_we_q     <= s_we_d;
      s_re_q     <= s_re_d;
      m0_rdata_q <= m0_rdata_d;
      m0_ready_q <= m0_ready_d;
      m0_err_q   <= m0_err_d;
      m1_rdata_q <= m1_rdata_d;
      m1_ready_q <= m1_ready_d;
      m1_err_q   <= m1_err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.s_addr     = s_addr_q;
  assign bus.s_wdata    = s_wdata_q;
  assign bus.s_we       = s_we_q;
  assign bus.s_re       = s_re_q;
  assign bus.m0_rdata   = m0_rdata_q;
  assign bus.m0_ready   = m0_ready_q;
  assign bus.m0_err     = m0_err_q;
  assign bus.m1_rdata   = m1_rdata_q;
  assign bus.m1_ready   = m1_ready_q;
  assign bus.m1_err     = m1_err_q;
  assign timeout_pulse  = tmo_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single memory port between the instruction-fetch requester (m0) and the load/store requester (m1).
- Selects one requester and holds the transaction on the memory-subsystem port until it completes, then returns data and a one-cycle ready pulse to the winner.
- Data port has priority, with bounded starvation of fetch.
- A watchdog terminates hung transactions with an error response.

Parameters:
- STARVE_LIMIT, 4: consecutive m1 grants allowed while m0 is pending before m0 is forced; range 1..15.
- TIMEOUT_CYCLES, 256: cycles in BUSY without s_ready before abort; range 2..65535.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on a timed-out transaction.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- m0_req  input  1  fetch request; held high with m0_addr stable until m0_ready.
- m0_addr  input  32  fetch address.
- m0_rdata  output  32  fetch read data; valid only while m0_ready=1.
- m0_ready  output  1  one-cycle completion pulse.
- m0_err  output  1  qualifies m0_ready; the transaction timed out.
- m1_req  input  1  load/store request; held with addr/we/wdata stable until m1_ready.
- m1_we  input  1  1 = store, 0 = load.
- m1_addr  input  32  data address.
- m1_wdata  input  32  store data.
- m1_rdata  output  32  load data; valid while m1_ready=1.
- m1_ready  output  1  one-cycle completion pulse.
- m1_err  output  1  qualifies m1_ready; the transaction timed out.
- s_addr  output  32  memory-port address (registered).
- s_wdata  output  32  memory-port write data (registered).
- s_we  output  1  write strobe, held until s_ready.
- s_re  output  1  read strobe, held until s_ready.
- s_rdata  input  32  memory-port read data, valid with s_ready.
- s_ready  input  1  memory-port completion.
- timeout_pulse  output  1  one-cycle pulse when a timeout abort occurs.

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; all outputs 0; starvation and timeout counters 0.
- Reset asserted mid-transaction discards the transaction. No ready is issued, and the requester must reissue after reset.
- The FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high, arbitrate, register the winner's addr/wdata/we and the owner ID, then go to BUSY.
  - s_re or s_we is asserted on the cycle after the request is sampled, so there is one cycle of request-to-strobe latency.
  - If no req is high, stay in IDLE.
- Arbitration:
  - m1 wins by default.
  - m0 wins if only m0 requests, or if starve_cnt == STARVE_LIMIT and m0_req=1.
  - starve_cnt increments on each m1 grant made while m0_req=1, saturating at STARVE_LIMIT.
  - starve_cnt clears on any m0 grant, and on any IDLE cycle with m0_req=0.
- BUSY:
  - s_re = ~owner_we and s_we = owner_we; s_addr and s_wdata are held constant.
  - tmo_cnt counts up from 0 on each BUSY cycle.
  - If s_ready=1: capture s_rdata, deassert the strobes at the next edge, go to RESP with err=0.
  - Else if tmo_cnt == TIMEOUT_CYCLES-1: deassert the strobes, load ERR_DATA, set err=1, pulse timeout_pulse in the RESP cycle, go to RESP.
  - If s_ready arrives in the same cycle as the timeout, s_ready wins: normal completion, no err.
- RESP (exactly 1 cycle):
  - Owner's mX_ready=1, mX_rdata = captured data, mX_err = err flag.
  - The non-owner's ready, rdata and err stay 0.
  - No arbitration happens in RESP; the next state is IDLE.
  - Result: a zero-wait memory completes a transaction in 3 cycles (IDLE, BUSY, RESP).
- Stores: in RESP, rdata is driven with the captured s_rdata but carries no meaning.
- Requester drops req while owned: the transaction is still completed and ready is still pulsed. This is a protocol violation, and no assertion is raised in RTL.
- Outputs s_*, mX_*, and timeout_pulse are all driven directly from registers; none are combinational.
- tmo_cnt width is clog2(TIMEOUT_CYCLES). starve_cnt is 4 bits.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=2'd0, BUSY=2'd1, RESP=2'd2;
  - owner constants: OWN_M0=1'b0, OWN_M1=1'b1;
  - ERR_DATA default.
- One natural sub-module: mem_port_watchdog. It owns the timeout counter, takes clear/enable, and outputs expire. It can be reused later for the peripheral bus.

Test Plan:
1. Single fetch: m0_req with addr 0x0000_0100; memory returns s_ready with 0x0000_0013 two cycles after s_re -> s_re high 2 cycles, then m0_ready=1 for exactly 1 cycle with m0_rdata=0x13 and m0_err=0.
2. Collision: m0_req and m1_req (store 0x1234_5678 to 0x2000) rise together, zero-wait memory -> s_we with that addr/data first, m1_ready; then m0 read, m0_ready; total 6 cycles.
3. Starvation: m1 reissues every transaction and m0_req is held -> grant order m1, m1, m1, m1, m0, then m1 resumes.
4. Timeout: TIMEOUT_CYCLES=16, s_ready held 0 on an m1 load -> s_re high 16 cycles; then m1_ready=1, m1_err=1, m1_rdata=0xDEADBEEF, timeout_pulse=1 in the same cycle.
5. s_ready coinciding with the 16th BUSY cycle -> normal completion: m1_err=0, timeout_pulse=0, data from s_rdata.
6. resetn dropped mid-BUSY (asynchronous, between edges) -> s_re and all ready outputs 0 immediately. After release, the FSM is in IDLE and no ready pulse is issued for the aborted request.
